// File: rtl/disp_signature.sv
// Frame-signature probe: captures one frame on request and reports CRC-16, pixel/line counts
// and geometry error. Optional coordinate check enabled by DISP_SIGNATURE_COORD_CHECK_EN.
module disp_signature #(
  parameter int          BPC      = 5,
  parameter int          CORDW    = 16,
  parameter int          H_RES    = 672,
  parameter int          V_RES    = 384,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic signed [CORDW-1:0] disp_x,
  input  logic signed [CORDW-1:0] disp_y,
  input  logic                    disp_de,
  input  logic                    disp_frame,
  input  logic [BPC-1:0]          disp_r,
  input  logic [BPC-1:0]          disp_g,
  input  logic [BPC-1:0]          disp_b,
  input  logic                    cap_req,
  output logic                    cap_busy,
  output logic                    sig_valid,
  input  logic                    sig_ack,
  output logic [15:0]             sig_crc,
  output logic [31:0]             sig_pix,
  output logic [CORDW-1:0]        sig_lines,
  output logic                    sig_err,
  output logic                    sig_coord_err
);

  localparam int W = 3 * BPC;

  typedef enum logic [1:0] {IDLE, ARM, CAPT, DONE} state_t;

  state_t           state;
  logic [15:0]      crc, crc_base;
  logic [31:0]      pix, pix_base;
  logic [CORDW-1:0] lines, lines_base, linepix, linepix_base;
  logic             width_err, width_err_base;
  logic             de_prev;
  logic             accum;
  logic [W-1:0]     pixel;

  // Unrolled MSB-first CRC-16/0x1021 over one W-bit word.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [W-1:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = W - 1; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  assign pixel    = {disp_r, disp_g, disp_b};
  assign cap_busy = (state == ARM) || (state == CAPT);

  // Accumulate on the start edge (from fresh values) and on every non-terminating CAPT cycle.
  assign accum = ((state == ARM) && disp_frame) || ((state == CAPT) && !disp_frame);

  always_comb begin
    crc_base       = crc;
    pix_base       = pix;
    lines_base     = lines;
    linepix_base   = linepix;
    width_err_base = width_err;
    if (state == ARM) begin
      crc_base       = CRC_INIT;
      pix_base       = '0;
      lines_base     = '0;
      linepix_base   = '0;
      width_err_base = 1'b0;
    end
  end

`ifdef DISP_SIGNATURE_COORD_CHECK_EN
  logic coord_err, coord_err_base;
  assign coord_err_base = (state == ARM) ? 1'b0 : coord_err;
`else
  logic coord_unused;
  assign coord_unused  = ^{disp_x, disp_y};
  assign sig_coord_err = 1'b0;
`endif

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state     <= IDLE;
      crc       <= CRC_INIT;
      pix       <= '0;
      lines     <= '0;
      linepix   <= '0;
      width_err <= 1'b0;
      de_prev   <= 1'b0;
      sig_valid <= 1'b0;
      sig_crc   <= '0;
      sig_pix   <= '0;
      sig_lines <= '0;
      sig_err   <= 1'b0;
`ifdef DISP_SIGNATURE_COORD_CHECK_EN
      coord_err     <= 1'b0;
      sig_coord_err <= 1'b0;
`endif
    end else begin
      de_prev <= disp_de;

      // NOTE: later non-blocking assignments to the same register override earlier ones,
      // so defaults are written first and the pixel/line-end updates refine them.
      if (accum) begin
        crc       <= crc_base;
        pix       <= pix_base;
        lines     <= lines_base;
        linepix   <= linepix_base;
        width_err <= width_err_base;
`ifdef DISP_SIGNATURE_COORD_CHECK_EN
        coord_err <= coord_err_base;
`endif
        if (disp_de) begin
          crc     <= crc16_step(crc_base, pixel);
          pix     <= pix_base + 32'd1;
          linepix <= linepix_base + 1'b1;
`ifdef DISP_SIGNATURE_COORD_CHECK_EN
          if ((disp_x != linepix_base) || (disp_y != lines_base)) coord_err <= 1'b1;
`endif
        end else if ((state == CAPT) && de_prev) begin
          lines   <= lines + 1'b1;
          linepix <= '0;
          if (32'(linepix) != 32'(H_RES)) width_err <= 1'b1;
        end
      end

      case (state)
        IDLE: if (cap_req) state <= ARM;
        ARM:  if (disp_frame) state <= CAPT;
        CAPT: if (disp_frame) begin
          state     <= DONE;
          sig_valid <= 1'b1;
          sig_crc   <= crc;
          sig_pix   <= pix;
          sig_lines <= lines;
          sig_err   <= width_err | (32'(lines) != 32'(V_RES));
`ifdef DISP_SIGNATURE_COORD_CHECK_EN
          sig_coord_err <= coord_err;
`endif
        end
        DONE: if (sig_ack) begin
          sig_valid <= 1'b0;
          state     <= cap_req ? ARM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_signature.sv
// Directed self-checking bench for disp_signature with a 4x2 frame geometry.
module tb_disp_signature;

  localparam int BPC   = 5;
  localparam int CORDW = 16;

  logic                    clk_pix = 1'b0;
  logic                    rst_pix;
  logic signed [CORDW-1:0] disp_x, disp_y;
  logic                    disp_de, disp_frame;
  logic [BPC-1:0]          disp_r, disp_g, disp_b;
  logic                    cap_req, sig_ack;
  logic                    cap_busy, sig_valid, sig_err, sig_coord_err;
  logic [15:0]             sig_crc;
  logic [31:0]             sig_pix;
  logic [CORDW-1:0]        sig_lines;

  int checks   = 0;
  int failures = 0;

  disp_signature #(.BPC(BPC), .CORDW(CORDW), .H_RES(4), .V_RES(2), .CRC_INIT(16'hFFFF)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix),
    .disp_x(disp_x), .disp_y(disp_y), .disp_de(disp_de), .disp_frame(disp_frame),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
    .cap_req(cap_req), .cap_busy(cap_busy), .sig_valid(sig_valid), .sig_ack(sig_ack),
    .sig_crc(sig_crc), .sig_pix(sig_pix), .sig_lines(sig_lines),
    .sig_err(sig_err), .sig_coord_err(sig_coord_err)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // Reference CRC: data word aligned to the top of the register, then shifted out.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [14:0] w);
    logic [15:0] r;
    r = c ^ {w, 1'b0};
    for (int i = 0; i < 15; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_n(input int n);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) r = crc_model(r, 15'h0443);
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic pulse_frame();
    disp_frame = 1'b1;
    cycle();
    disp_frame = 1'b0;
  endtask

  task automatic send_line(input int y, input int n, input bit bad_first);
    for (int i = 0; i < n; i++) begin
      disp_de = 1'b1;
      disp_x  = (i == 0 && bad_first) ? 16'sd5 : 16'(i);
      disp_y  = 16'(y);
      cycle();
    end
    disp_de = 1'b0;
    disp_x  = '0;
    cycle();
    cycle();
  endtask

  task automatic request();
    cap_req = 1'b1;
    cycle();
    cap_req = 1'b0;
  endtask

  // Start pulse, two lines, and the terminating pulse with sig_valid timing checks.
  task automatic frame(input int len1, input bit bad_first, input bit req_in_capt);
    pulse_frame();
    if (req_in_capt) request();
    cycle();
    send_line(0, 4, bad_first);
    send_line(1, len1, 1'b0);
    check("valid_before_end", sig_valid, 1'b0);
    pulse_frame();
    check("valid_after_end", sig_valid, 1'b1);
  endtask

  task automatic ack();
    sig_ack = 1'b1;
    cycle();
    sig_ack = 1'b0;
  endtask

  initial begin
    rst_pix = 1'b1; disp_x = '0; disp_y = '0; disp_de = 1'b0; disp_frame = 1'b0;
    disp_r = 5'd1; disp_g = 5'd2; disp_b = 5'd3; cap_req = 1'b0; sig_ack = 1'b0;
    #12;
    check("rst_busy", cap_busy, 1'b0);
    check("rst_valid", sig_valid, 1'b0);
    check("rst_crc", sig_crc, 16'h0);
    rst_pix = 1'b0;
    cycle();

    // Empty frame
    request();
    check("arm_busy", cap_busy, 1'b1);
    pulse_frame();
    cycle(); cycle();
    pulse_frame();
    check("empty_valid", sig_valid, 1'b1);
    check("empty_crc", sig_crc, 16'hFFFF);
    check("empty_pix", sig_pix, 32'd0);
    check("empty_lines", sig_lines, 32'd0);
    check("empty_err", sig_err, 1'b1);
    ack();
    check("empty_ack_valid", sig_valid, 1'b0);
    check("empty_ack_busy", cap_busy, 1'b0);

    // Good frame, then asynchronous reset mid-cycle while the result is held
    request();
    frame(4, 1'b0, 1'b0);
    check("good_crc", sig_crc, crc_n(8));
    check("good_pix", sig_pix, 32'd8);
    check("good_lines", sig_lines, 32'd2);
    check("good_err", sig_err, 1'b0);
    check("good_coord", sig_coord_err, 1'b0);
    check("good_busy", cap_busy, 1'b0);
    @(negedge clk_pix);
    #2 rst_pix = 1'b1;
    #1;
    check("arst_valid", sig_valid, 1'b0);
    check("arst_pix", sig_pix, 32'd0);
    check("arst_crc", sig_crc, 16'h0);
    check("arst_lines", sig_lines, 32'd0);
    check("arst_err", sig_err, 1'b0);
    check("arst_busy", cap_busy, 1'b0);
    cycle();
    rst_pix = 1'b0;
    cycle();

    // Short second line, with a stray cap_req during capture
    request();
    frame(3, 1'b0, 1'b1);
    check("short_err", sig_err, 1'b1);
    check("short_pix", sig_pix, 32'd7);
    check("short_lines", sig_lines, 32'd2);
    check("short_crc", sig_crc, crc_n(7));
    ack();
    cycle();
    check("short_idle_busy", cap_busy, 1'b0);
    check("short_idle_valid", sig_valid, 1'b0);

    // Back-to-back capture
    request();
    frame(4, 1'b0, 1'b0);
    sig_ack = 1'b1; cap_req = 1'b1;
    cycle();
    sig_ack = 1'b0; cap_req = 1'b0;
    check("b2b_busy", cap_busy, 1'b1);
    check("b2b_valid_low", sig_valid, 1'b0);
    check("b2b_held_pix", sig_pix, 32'd8);
    frame(3, 1'b0, 1'b0);
    check("b2b_pix", sig_pix, 32'd7);
    check("b2b_err", sig_err, 1'b1);

    // Reset during CAPT
    sig_ack = 1'b1; cap_req = 1'b1;
    cycle();
    sig_ack = 1'b0; cap_req = 1'b0;
    pulse_frame();
    send_line(0, 4, 1'b0);
    check("capt_busy", cap_busy, 1'b1);
    rst_pix = 1'b1;
    cycle();
    rst_pix = 1'b0;
    check("capt_rst_busy", cap_busy, 1'b0);
    send_line(1, 4, 1'b0);
    pulse_frame();
    cycle();
    check("capt_rst_valid", sig_valid, 1'b0);
    check("capt_rst_pix", sig_pix, 32'd0);

    // Coordinate check: first pixel reports x=5
    request();
    frame(4, 1'b1, 1'b0);
`ifdef DISP_SIGNATURE_COORD_CHECK_EN
    check("coord_err", sig_coord_err, 1'b1);
`else
    check("coord_err", sig_coord_err, 1'b0);
`endif
    check("coord_geom_err", sig_err, 1'b0);
    check("coord_crc", sig_crc, crc_n(8));
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
